lcd_arbiter: RTL and testbench
==============================

LCD_ARBITER -- requirements
Module: lcd_arbiter

Interface
REQ-001 Parameter EN_HIGH_CYC, default 50_000, number of clk cycles lcd_en is held high per write.
REQ-002 Parameter EN_LOW_CYC, default 50_000, number of clk cycles lcd_en is held low after each normal write.
REQ-003 Parameter CLR_LOW_CYC, default 100_000, low-phase length after a clear or home command.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 req0_valid  in  1  requester 0 has a byte to write.
REQ-007 req0_rs  in  1  requester 0 register select (0 command, 1 character).
REQ-008 req0_data  in  8  requester 0 byte.
REQ-009 req0_ready  out  1  requester 0 byte accepted this cycle.
REQ-010 req1_valid, req1_rs, req1_data, req1_ready: same as REQ-006..009, for requester 1.
REQ-011 lcd_data  out  8  HD44780 data bus, registered.
REQ-012 lcd_en  out  1  HD44780 enable, registered.
REQ-013 lcd_rs  out  1  HD44780 register select, registered.
REQ-014 lcd_rw  out  1  HD44780 read/write; tied 0 (write only).
REQ-015 init_done  out  1  power-up command sequence complete.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 States: SETUP, EN_HI, EN_LO, IDLE.
- init_idx: 0..3, init-in-progress flag.
- cnt: counter at least 32 bits wide.
- last_grant: 1 bit.
REQ-018 Init sequence, rs=0, in order: 0x38, 0x0C, 0x01, 0x06.
- Each byte is issued as one full write cycle (REQ-019).
REQ-019 Write cycle:
- SETUP: exactly 1 cycle; lcd_data/lcd_rs hold the byte; lcd_en=0.
- EN_HI: lcd_en=1 for exactly EN_HIGH_CYC cycles.
- EN_LO: lcd_en=0 for exactly EN_LOW_CYC cycles, or CLR_LOW_CYC cycles if rs=0 and byte is 0x01, 0x02 or 0x03.
- cnt clears on every state change.
REQ-020 lcd_data and lcd_rs load on the edge that enters SETUP; they hold unchanged through EN_HI and EN_LO, and in IDLE.
REQ-021 End of EN_LO during init:
- If init_idx<3: init_idx increments; next state SETUP with the next init byte.
- If init_idx=3: init_done sets to 1; next state IDLE.
REQ-022 End of EN_LO after init: next state IDLE.
REQ-023 reqN_ready is combinational: 1 only when state=IDLE, init_done=1, reqN_valid=1, and N is granted.
REQ-024 Grant rules in IDLE:
- Only one requester valid: that requester is granted.
- Both valid: grant the requester not equal to last_grant (round-robin).
REQ-025 On accept (valid&&ready):
- Byte and rs are captured into lcd_data/lcd_rs.
- last_grant <= N; state <= SETUP.
- Accept at edge T: lcd_data valid after T; lcd_en rises at edge T+1.
REQ-026 At most one ready is high per cycle; ready is never high outside IDLE.
REQ-027 A requester holds valid/rs/data stable until ready; dropping valid before ready is legal and nothing is written.
REQ-028 Requests arriving before init_done=1 are held off (ready=0) and are not lost while valid stays high.
REQ-029 Back-to-back accepts: a minimum of 1 IDLE cycle occurs between consecutive write cycles.

Reset
REQ-030 rst=1 at an edge forces, regardless of current state (including mid-EN_HI):
- Outputs: lcd_data=0x00, lcd_en=0, lcd_rs=0, lcd_rw=0, init_done=0, busy=1, ready outputs 0.
- Internal: init_idx=0, cnt=0, last_grant=1.
- State: SETUP pending init byte 0.
REQ-031 First edge with rst=0 loads lcd_data=0x38, lcd_rs=0; next edge raises lcd_en.
REQ-032 Reset asserted mid-write aborts the write; the init sequence restarts fully.

Verification (EN_HIGH_CYC=4, EN_LOW_CYC=4, CLR_LOW_CYC=10)
REQ-033 Release reset with no requests:
- lcd_data sequence 0x38, 0x0C, 0x01, 0x06.
- Each has 4 EN-high cycles; low phases 4, 4, 10, 4.
- init_done=1 exactly 1+4+4 + 1+4+4 + 1+4+10 + 1+4+4 cycles after the first post-reset edge.
REQ-034 After init, req0 {rs=1, 0x35}: ready for 1 cycle; lcd_rs=1, lcd_data=0x35; EN high 4 cycles then low 4; busy drops.
REQ-035 Both requesters held valid continuously: grants alternate 0,1,0,1; each ready is 1-cycle wide; never both ready high together.
REQ-036 req1 writes {rs=0, 0x01}: EN_LO lasts 10 cycles; {rs=0, 0x0C} then lasts 4.
REQ-037 rst pulsed during EN_HI of a user write: lcd_en=0 on the next edge; init_done=0; init restarts at 0x38.
REQ-038 req0_valid held from reset release: ready stays 0 until init_done=1; accepted in the first IDLE cycle.

Source files
------------

// File: rtl/lcd_arbiter.sv
// Two-requester round-robin arbiter driving an HD44780 LCD in 8-bit write-only mode.
// Runs the power-up command sequence itself, then times each accepted write on lcd_en.
module lcd_arbiter #(
  parameter int unsigned EN_HIGH_CYC = 50_000,
  parameter int unsigned EN_LOW_CYC  = 50_000,
  parameter int unsigned CLR_LOW_CYC = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] lcd_data,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       init_done,
  output logic       busy
);

  typedef enum logic [1:0] {StSetup, StEnHi, StEnLo, StIdle} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  init_idx_q, init_idx_d;
  logic        init_done_q, init_done_d;
  logic        last_grant_q, last_grant_d;
  // Set by reset: the first post-reset edge loads init byte 0 while staying in StSetup.
  logic        pend_q, pend_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        en_q;

  logic        grant1;
  logic        clr_cmd;
  logic [31:0] low_last;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h38;
      2'd1:    b = 8'h0C;
      2'd2:    b = 8'h01;
      default: b = 8'h06;
    endcase
    return b;
  endfunction

  // Clear and home commands need the long settle time.
  assign clr_cmd  = !rs_q && (data_q[7:2] == 6'b0) && (data_q[1:0] != 2'b0);
  assign low_last = clr_cmd ? 32'(CLR_LOW_CYC - 1) : 32'(EN_LOW_CYC - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StSetup;
      cnt_q        <= '0;
      init_idx_q   <= '0;
      init_done_q  <= 1'b0;
      last_grant_q <= 1'b1;
      pend_q       <= 1'b1;
      data_q       <= '0;
      rs_q         <= 1'b0;
      en_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      init_idx_q   <= init_idx_d;
      init_done_q  <= init_done_d;
      last_grant_q <= last_grant_d;
      pend_q       <= pend_d;
      data_q       <= data_d;
      rs_q         <= rs_d;
      en_q         <= (state_d == StEnHi);
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 32'd1;
    init_idx_d   = init_idx_q;
    init_done_d  = init_done_q;
    last_grant_d = last_grant_q;
    pend_d       = pend_q;
    data_d       = data_q;
    rs_d         = rs_q;
    unique case (state_q)
      StSetup: begin
        cnt_d = '0;
        if (pend_q) begin
          pend_d = 1'b0;
          data_d = init_byte(2'd0);
          rs_d   = 1'b0;
        end else begin
          state_d = StEnHi;
        end
      end
      StEnHi: begin
        if (cnt_q == 32'(EN_HIGH_CYC - 1)) begin
          state_d = StEnLo;
          cnt_d   = '0;
        end
      end
      StEnLo: begin
        if (cnt_q == low_last) begin
          cnt_d = '0;
          if (!init_done_q && (init_idx_q != 2'd3)) begin
            init_idx_d = init_idx_q + 2'd1;
            data_d     = init_byte(init_idx_q + 2'd1);
            rs_d       = 1'b0;
            state_d    = StSetup;
          end else begin
            init_done_d = 1'b1;
            state_d     = StIdle;
          end
        end
      end
      StIdle: begin
        cnt_d = '0;
        if (req0_ready) begin
          data_d       = req0_data;
          rs_d         = req0_rs;
          last_grant_d = 1'b0;
          state_d      = StSetup;
        end else if (req1_ready) begin
          data_d       = req1_data;
          rs_d         = req1_rs;
          last_grant_d = 1'b1;
          state_d      = StSetup;
        end
      end
      default: state_d = StSetup;
    endcase
  end

  always_comb begin
    busy       = (state_q != StIdle);
    grant1     = req1_valid && (!req0_valid || !last_grant_q);
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if ((state_q == StIdle) && init_done_q && !rst) begin
      req1_ready = grant1;
      req0_ready = req0_valid && !grant1;
    end
  end

  assign lcd_data  = data_q;
  assign lcd_rs    = rs_q;
  assign lcd_en    = en_q;
  assign lcd_rw    = 1'b0;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_arbiter.sv
// Directed bench for lcd_arbiter with short timing parameters (EN 4/4, clear-low 10).
module tb_lcd_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_rs, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_rs, req1_ready;
  logic [7:0] req1_data;
  logic [7:0] lcd_data;
  logic       lcd_en, lcd_rs, lcd_rw, init_done, busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] init_b [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  int         lows   [4] = '{4, 4, 10, 4};
  logic       exp_en   [1:43];
  logic [7:0] exp_data [1:43];

  always #5 clk = ~clk;

  lcd_arbiter #(
    .EN_HIGH_CYC (4),
    .EN_LOW_CYC  (4),
    .CLR_LOW_CYC (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_rs    (req0_rs),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_rs    (req1_rs),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .lcd_data   (lcd_data),
    .lcd_en     (lcd_en),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .init_done  (init_done),
    .busy       (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the sample just after the accept edge; returns at the first IDLE sample.
  task automatic run_write(output int hi, output int lo);
    hi = 0;
    lo = 0;
    tick;
    while (lcd_en && hi < 100) begin
      hi++;
      tick;
    end
    while (busy && !lcd_en && lo < 100) begin
      lo++;
      tick;
    end
  endtask

  task automatic single_write(input bit who, input logic rs, input logic [7:0] d, input int exp_lo,
                              input string tag);
    int hi, lo;
    if (who) begin
      req1_rs = rs; req1_data = d; req1_valid = 1'b1;
    end else begin
      req0_rs = rs; req0_data = d; req0_valid = 1'b1;
    end
    #1;
    chk({tag, "_ready0"}, req0_ready, !who);
    chk({tag, "_ready1"}, req1_ready, who);
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk({tag, "_data"}, lcd_data, d);
    chk({tag, "_rs"}, lcd_rs, rs);
    chk({tag, "_en_setup"}, lcd_en, 1'b0);
    chk({tag, "_ready_off"}, {req0_ready, req1_ready}, 2'b00);
    run_write(hi, lo);
    chk({tag, "_hi"}, hi, 4);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_busy_drop"}, busy, 1'b0);
    chk({tag, "_data_held"}, lcd_data, d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, w, seen;
    k = 1;
    for (int b = 0; b < 4; b++) begin
      exp_en[k] = 1'b0; exp_data[k] = init_b[b]; k++;
      for (int i = 0; i < 4; i++) begin
        exp_en[k] = 1'b1; exp_data[k] = init_b[b]; k++;
      end
      for (int i = 0; i < lows[b]; i++) begin
        exp_en[k] = 1'b0; exp_data[k] = init_b[b]; k++;
      end
    end
    exp_en[43]   = 1'b0;
    exp_data[43] = 8'h06;

    rst = 1'b1;
    req0_valid = 1'b0; req0_rs = 1'b0; req0_data = 8'h00;
    req1_valid = 1'b0; req1_rs = 1'b0; req1_data = 8'h00;
    repeat (3) tick;
    chk("rst_data", lcd_data, 8'h00);
    chk("rst_en", lcd_en, 1'b0);
    chk("rst_rs", lcd_rs, 1'b0);
    chk("rst_rw", lcd_rw, 1'b0);
    chk("rst_done", init_done, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_ready", {req0_ready, req1_ready}, 2'b00);

    // Power-up sequence, cycle by cycle.
    rst = 1'b0;
    for (int s = 1; s <= 43; s++) begin
      tick;
      chk($sformatf("init_en_%0d", s), lcd_en, exp_en[s]);
      chk($sformatf("init_data_%0d", s), lcd_data, exp_data[s]);
      chk($sformatf("init_rs_%0d", s), lcd_rs, 1'b0);
      chk($sformatf("init_done_%0d", s), init_done, s == 43);
      chk($sformatf("init_busy_%0d", s), busy, s != 43);
    end

    single_write(1'b0, 1'b1, 8'h35, 4, "w0_35");
    single_write(1'b1, 1'b0, 8'h01, 10, "w1_clr");
    single_write(1'b1, 1'b0, 8'h0C, 4, "w1_0c");

    // Both held valid; last grant was requester 1, so 0,1,0,1.
    req0_rs = 1'b1; req0_data = 8'hA0; req0_valid = 1'b1;
    req1_rs = 1'b1; req1_data = 8'hB1; req1_valid = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      w = 0;
      while (!(req0_ready || req1_ready) && w < 50) begin
        tick;
        w++;
      end
      chk($sformatf("rr_both_%0d", g), req0_ready && req1_ready, 1'b0);
      chk($sformatf("rr_r0_%0d", g), req0_ready, (g % 2) == 0);
      chk($sformatf("rr_r1_%0d", g), req1_ready, (g % 2) == 1);
      tick;
      chk($sformatf("rr_data_%0d", g), lcd_data, ((g % 2) == 0) ? 8'hA0 : 8'hB1);
      chk($sformatf("rr_pulse_%0d", g), {req0_ready, req1_ready}, 2'b00);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    w = 0;
    while (busy && w < 50) begin
      tick;
      w++;
    end
    chk("rr_idle", busy, 1'b0);

    // Reset during EN_HI of a user write.
    req0_rs = 1'b1; req0_data = 8'h41; req0_valid = 1'b1;
    #1;
    chk("abort_ready", req0_ready, 1'b1);
    tick;
    req0_valid = 1'b0;
    tick;
    chk("abort_en_hi", lcd_en, 1'b1);
    rst = 1'b1;
    req0_rs = 1'b1; req0_data = 8'h55; req0_valid = 1'b1;
    tick;
    chk("abort_en", lcd_en, 1'b0);
    chk("abort_done", init_done, 1'b0);
    chk("abort_busy", busy, 1'b1);
    chk("abort_data", lcd_data, 8'h00);
    chk("abort_ready0", req0_ready, 1'b0);

    // Request held from reset release is deferred until init completes.
    rst = 1'b0;
    tick;
    chk("restart_data", lcd_data, 8'h38);
    chk("restart_en", lcd_en, 1'b0);
    seen = 0;
    for (int s = 2; s <= 42; s++) begin
      tick;
      if (req0_ready) seen++;
    end
    chk("held_ready_seen", seen, 0);
    tick;
    chk("held_done", init_done, 1'b1);
    chk("held_ready", req0_ready, 1'b1);
    tick;
    req0_valid = 1'b0;
    chk("held_data", lcd_data, 8'h55);
    chk("held_rs", lcd_rs, 1'b1);
    w = 0;
    while (busy && w < 50) begin
      tick;
      w++;
    end
    chk("held_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
